// File: rtl/interrupt_dispatcher.sv
// CPU-side interrupt dispatcher: samples the controller's pending interrupt at
// instruction boundaries, runs the req/ack entry handshake and issues dismiss/create strobes.
module interrupt_dispatcher #(
  parameter logic [11:0] VECTOR_BASE = 12'o0100,
  parameter logic [11:0] NONE_CODE   = 12'o7777
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] next_interrupt,
  output logic        ctl_dismiss,
  output logic        ctl_create,
  output logic [11:0] ctl_data,
  input  logic        boundary,
  output logic        int_req,
  input  logic        int_ack,
  output logic [11:0] vector,
  output logic [11:0] cur_irq,
  output logic        in_service,
  output logic        ien,
  input  logic        cpu_ien_set,
  input  logic        cpu_ien_clr,
  input  logic        cpu_rti,
  input  logic        cpu_swi,
  input  logic [11:0] cpu_swi_num
);

  typedef enum logic [1:0] {IDLE, PEND, ENTER, SERVICE} state_t;

  state_t      state_q, state_d;
  logic        ien_q, ien_d;
  logic        int_req_q, int_req_d;
  logic        in_service_q, in_service_d;
  logic        ctl_dismiss_q, ctl_dismiss_d;
  logic        ctl_create_q, ctl_create_d;
  logic [11:0] ctl_data_q, ctl_data_d;
  logic [11:0] cur_irq_q, cur_irq_d;
  logic [11:0] vector_q, vector_d;
  logic        swi_pend_q, swi_pend_d;
  logic [11:0] swi_num_q, swi_num_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      ien_q         <= 1'b0;
      int_req_q     <= 1'b0;
      in_service_q  <= 1'b0;
      ctl_dismiss_q <= 1'b0;
      ctl_create_q  <= 1'b0;
      ctl_data_q    <= 12'd0;
      cur_irq_q     <= NONE_CODE;
      vector_q      <= 12'd0;
      swi_pend_q    <= 1'b0;
      swi_num_q     <= 12'd0;
    end else begin
      state_q       <= state_d;
      ien_q         <= ien_d;
      int_req_q     <= int_req_d;
      in_service_q  <= in_service_d;
      ctl_dismiss_q <= ctl_dismiss_d;
      ctl_create_q  <= ctl_create_d;
      ctl_data_q    <= ctl_data_d;
      cur_irq_q     <= cur_irq_d;
      vector_q      <= vector_d;
      swi_pend_q    <= swi_pend_d;
      swi_num_q     <= swi_num_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    ien_d         = ien_q;
    int_req_d     = int_req_q;
    in_service_d  = in_service_q;
    ctl_dismiss_d = 1'b0;
    ctl_create_d  = 1'b0;
    ctl_data_d    = ctl_data_q;
    cur_irq_d     = cur_irq_q;
    vector_d      = vector_q;
    swi_pend_d    = swi_pend_q;
    swi_num_d     = swi_num_q;

    // Software enable control is frozen while entering or running a handler.
    if (state_q == IDLE || state_q == PEND) begin
      if (cpu_ien_clr)      ien_d = 1'b0;
      else if (cpu_ien_set) ien_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (ien_q && boundary && next_interrupt != NONE_CODE) begin
          cur_irq_d = next_interrupt;
          int_req_d = 1'b1;
          state_d   = PEND;
        end
      end
      PEND: begin
        if (cpu_ien_clr) begin
          int_req_d = 1'b0;
          cur_irq_d = NONE_CODE;
          state_d   = IDLE;
        end else if (int_ack) begin
          int_req_d     = 1'b0;
          ctl_dismiss_d = 1'b1;
          ctl_data_d    = cur_irq_q;
          vector_d      = VECTOR_BASE + {cur_irq_q[10:0], 1'b0};
          state_d       = ENTER;
        end
      end
      ENTER: begin
        ien_d        = 1'b0;
        in_service_d = 1'b1;
        state_d      = SERVICE;
      end
      SERVICE: begin
        if (cpu_rti) begin
          in_service_d = 1'b0;
          ien_d        = 1'b1;
          cur_irq_d    = NONE_CODE;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A create that would collide with the dismiss strobe is deferred one cycle;
    // a newer request replaces a deferred one so only a single create goes out.
    if (ctl_dismiss_d) begin
      if (cpu_swi) begin
        swi_pend_d = 1'b1;
        swi_num_d  = cpu_swi_num;
      end
    end else if (cpu_swi) begin
      ctl_create_d = 1'b1;
      ctl_data_d   = cpu_swi_num;
      swi_pend_d   = 1'b0;
    end else if (swi_pend_q) begin
      ctl_create_d = 1'b1;
      ctl_data_d   = swi_num_q;
      swi_pend_d   = 1'b0;
    end
  end

  assign ctl_dismiss = ctl_dismiss_q;
  assign ctl_create  = ctl_create_q;
  assign ctl_data    = ctl_data_q;
  assign int_req     = int_req_q;
  assign vector      = vector_q;
  assign cur_irq     = cur_irq_q;
  assign in_service  = in_service_q;
  assign ien         = ien_q;

endmodule

// File: tb/tb_interrupt_dispatcher.sv
// Directed bench for interrupt_dispatcher; a second instance with a high vector
// base shares all inputs and is used only for the vector wrap check.
module tb_interrupt_dispatcher;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] next_interrupt;
  logic        boundary, int_ack;
  logic        cpu_ien_set, cpu_ien_clr, cpu_rti, cpu_swi;
  logic [11:0] cpu_swi_num;

  logic        ctl_dismiss, ctl_create, int_req, in_service, ien;
  logic [11:0] ctl_data, vector, cur_irq;
  logic        w_dismiss, w_create, w_int_req, w_in_service, w_ien;
  logic [11:0] w_data, w_vector, w_cur_irq;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  interrupt_dispatcher dut (
    .clk(clk), .rst_n(rst_n), .next_interrupt(next_interrupt),
    .ctl_dismiss(ctl_dismiss), .ctl_create(ctl_create), .ctl_data(ctl_data),
    .boundary(boundary), .int_req(int_req), .int_ack(int_ack),
    .vector(vector), .cur_irq(cur_irq), .in_service(in_service), .ien(ien),
    .cpu_ien_set(cpu_ien_set), .cpu_ien_clr(cpu_ien_clr), .cpu_rti(cpu_rti),
    .cpu_swi(cpu_swi), .cpu_swi_num(cpu_swi_num)
  );

  interrupt_dispatcher #(.VECTOR_BASE(12'o7770)) dut_w (
    .clk(clk), .rst_n(rst_n), .next_interrupt(next_interrupt),
    .ctl_dismiss(w_dismiss), .ctl_create(w_create), .ctl_data(w_data),
    .boundary(boundary), .int_req(w_int_req), .int_ack(int_ack),
    .vector(w_vector), .cur_irq(w_cur_irq), .in_service(w_in_service), .ien(w_ien),
    .cpu_ien_set(cpu_ien_set), .cpu_ien_clr(cpu_ien_clr), .cpu_rti(cpu_rti),
    .cpu_swi(cpu_swi), .cpu_swi_num(cpu_swi_num)
  );

  task automatic chk(input string tag, input logic [11:0] got, input logic [11:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %o expected %o", tag, got, exp);
    end else begin
      $display("ok   %s: %o", tag, got);
    end
  endtask

  // Inputs applied now are sampled on the next edge; outputs read 1 ns after it.
  task automatic step();
    @(posedge clk);
    #1;
    boundary = 1'b0; int_ack = 1'b0; cpu_ien_set = 1'b0; cpu_ien_clr = 1'b0;
    cpu_rti = 1'b0; cpu_swi = 1'b0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " ien"},        {11'd0, ien},         12'd0);
    chk({tag, " int_req"},    {11'd0, int_req},     12'd0);
    chk({tag, " in_service"}, {11'd0, in_service},  12'd0);
    chk({tag, " dismiss"},    {11'd0, ctl_dismiss}, 12'd0);
    chk({tag, " create"},     {11'd0, ctl_create},  12'd0);
    chk({tag, " cur_irq"},    cur_irq,              12'o7777);
    chk({tag, " vector"},     vector,               12'd0);
    chk({tag, " ctl_data"},   ctl_data,             12'd0);
  endtask

  initial begin
    rst_n = 1'b0; next_interrupt = 12'o7777; cpu_swi_num = 12'd0;
    boundary = 1'b0; int_ack = 1'b0; cpu_ien_set = 1'b0; cpu_ien_clr = 1'b0;
    cpu_rti = 1'b0; cpu_swi = 1'b0;
    step(); step();
    rst_n = 1'b1;
    step();
    chk_reset("reset");

    // Basic entry of irq 3
    cpu_ien_set = 1'b1; step();
    chk("ien set", {11'd0, ien}, 12'd1);
    next_interrupt = 12'd3; boundary = 1'b1; step();
    chk("t1 int_req", {11'd0, int_req}, 12'd1);
    chk("t1 cur_irq", cur_irq, 12'd3);
    step();
    chk("t1 req held", {11'd0, int_req}, 12'd1);
    int_ack = 1'b1; step();
    chk("t1 enter req", {11'd0, int_req}, 12'd0);
    chk("t1 dismiss", {11'd0, ctl_dismiss}, 12'd1);
    chk("t1 data", ctl_data, 12'd3);
    chk("t1 vector", vector, 12'o0106);
    chk("t1 insvc early", {11'd0, in_service}, 12'd0);
    step();
    chk("t1 in_service", {11'd0, in_service}, 12'd1);
    chk("t1 ien", {11'd0, ien}, 12'd0);
    chk("t1 dismiss off", {11'd0, ctl_dismiss}, 12'd0);

    // No nesting; rti re-arms, then irq 1
    next_interrupt = 12'd1; boundary = 1'b1; cpu_ien_set = 1'b1; step();
    chk("t2 no nest", {11'd0, int_req}, 12'd0);
    chk("t2 ien ignored", {11'd0, ien}, 12'd0);
    cpu_rti = 1'b1; step();
    chk("t2 rti insvc", {11'd0, in_service}, 12'd0);
    chk("t2 rti ien", {11'd0, ien}, 12'd1);
    chk("t2 rti cur", cur_irq, 12'o7777);
    boundary = 1'b1; step();
    chk("t2 req", {11'd0, int_req}, 12'd1);
    chk("t2 cur", cur_irq, 12'd1);
    int_ack = 1'b1; step();
    chk("t2 vector", vector, 12'o0102);
    chk("t2 data", ctl_data, 12'd1);
    step(); cpu_rti = 1'b1; step();

    // cur_irq frozen in PEND
    next_interrupt = 12'd5; boundary = 1'b1; step();
    chk("t3 cur", cur_irq, 12'd5);
    next_interrupt = 12'd0; step();
    chk("t3 frozen", cur_irq, 12'd5);
    int_ack = 1'b1; step();
    chk("t3 dismiss", {11'd0, ctl_dismiss}, 12'd1);
    chk("t3 data", ctl_data, 12'd5);
    chk("t3 vector", vector, 12'o0112);
    step(); cpu_rti = 1'b1; step();

    // Withdraw in PEND (ien_clr beats ack)
    next_interrupt = 12'd2; boundary = 1'b1; step();
    chk("t3w req", {11'd0, int_req}, 12'd1);
    cpu_ien_clr = 1'b1; int_ack = 1'b1; step();
    chk("t3w req drop", {11'd0, int_req}, 12'd0);
    chk("t3w ien", {11'd0, ien}, 12'd0);
    chk("t3w cur", cur_irq, 12'o7777);
    chk("t3w no dismiss", {11'd0, ctl_dismiss}, 12'd0);
    step();
    chk("t3w no dismiss2", {11'd0, ctl_dismiss}, 12'd0);

    // SWI colliding with ENTER is deferred one cycle
    cpu_ien_set = 1'b1; step();
    next_interrupt = 12'd4; boundary = 1'b1; step();
    int_ack = 1'b1; cpu_swi = 1'b1; cpu_swi_num = 12'o0040; step();
    chk("t4 dismiss", {11'd0, ctl_dismiss}, 12'd1);
    chk("t4 no create", {11'd0, ctl_create}, 12'd0);
    chk("t4 dis data", ctl_data, 12'd4);
    step();
    chk("t4 create", {11'd0, ctl_create}, 12'd1);
    chk("t4 dismiss off", {11'd0, ctl_dismiss}, 12'd0);
    chk("t4 cr data", ctl_data, 12'o0040);
    step();
    chk("t4 create once", {11'd0, ctl_create}, 12'd0);
    chk("t4 data hold", ctl_data, 12'o0040);
    cpu_swi = 1'b1; cpu_swi_num = 12'o0021; step();
    chk("t4 swi svc", {11'd0, ctl_create}, 12'd1);
    chk("t4 swi data", ctl_data, 12'o0021);
    cpu_rti = 1'b1; step();

    // Vector wrap on the high-base instance
    next_interrupt = 12'd6; boundary = 1'b1; step();
    int_ack = 1'b1; step();
    chk("t5 vector", vector, 12'o0114);
    chk("t5 wrap", w_vector, 12'o0004);
    step(); cpu_rti = 1'b1; step();

    // NONE_CODE never requests; set+clr together clears
    next_interrupt = 12'o7777; boundary = 1'b1; step();
    chk("t5 none", {11'd0, int_req}, 12'd0);
    cpu_ien_set = 1'b1; cpu_ien_clr = 1'b1; step();
    chk("t5 set+clr", {11'd0, ien}, 12'd0);
    next_interrupt = 12'd7; boundary = 1'b1; step();
    chk("t5 ien0 no req", {11'd0, int_req}, 12'd0);

    // Reset in SERVICE
    cpu_ien_set = 1'b1; step();
    boundary = 1'b1; step();
    int_ack = 1'b1; step();
    step();
    chk("t6 in svc", {11'd0, in_service}, 12'd1);
    rst_n = 1'b0; cpu_rti = 1'b1; step();
    chk_reset("t6 rst svc");

    // Reset in PEND with ack
    rst_n = 1'b1; cpu_ien_set = 1'b1; step();
    boundary = 1'b1; step();
    chk("t6 pend req", {11'd0, int_req}, 12'd1);
    rst_n = 1'b0; int_ack = 1'b1; step();
    chk_reset("t6 rst pend");
    rst_n = 1'b1; step();
    chk("t6 post dismiss", {11'd0, ctl_dismiss}, 12'd0);
    chk("t6 post req", {11'd0, int_req}, 12'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
